// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter: single register-file write port shared by ALU and load  |
// | writeback, with an in-order ALU deferral queue.       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        alu_pred_ok,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_pred_ok,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic        stall,
  output logic [2:0]  q_count,
  output logic        overflow
);

  localparam int              PW         = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0]      c_depth    = 3'(DEPTH);
  localparam logic [2:0]      c_depth_m1 = 3'(DEPTH - 1);
  localparam logic [PW-1:0]   c_last     = PW'(DEPTH - 1);

  logic [4:0]       r_q_rd   [DEPTH];
  logic [31:0]      r_q_data [DEPTH];
  logic [DEPTH-1:0] r_q_vld;
  logic [PW-1:0]    r_head, r_tail;
  logic [2:0]       r_count;
  logic             r_overflow;
  logic             r_wr_en;
  logic [4:0]       r_wr_rd;
  logic [31:0]      r_wr_data;

  logic w_alu_ok, w_mem_ok, w_q_hit, w_mem_own, w_deq, w_alu_direct, w_enq, w_drop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  // r0 is hardwired and r30 is reserved, so neither is ever written
  assign w_alu_ok = alu_valid && alu_pred_ok && (alu_rd != 5'd0) && (alu_rd != 5'd30);
  assign w_mem_ok = mem_valid && mem_pred_ok && (mem_rd != 5'd0) && (mem_rd != 5'd30);

  always_comb begin
    w_q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_vld[i] && (r_q_rd[i] == mem_rd)) w_q_hit = 1'b1;
    end
  end

  // The load is older, so a younger ALU write to the same rd makes it dead
  assign w_mem_own    = w_mem_ok && !w_q_hit && !(w_alu_ok && (alu_rd == mem_rd));
  assign w_deq        = !w_mem_own && (r_count != 3'd0);
  assign w_alu_direct = !w_mem_own && (r_count == 3'd0) && w_alu_ok;
  assign w_enq        = w_alu_ok && !w_alu_direct && (w_deq || (r_count != c_depth));
  assign w_drop       = w_alu_ok && !w_alu_direct && !w_deq && (r_count == c_depth);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_rd    <= 5'd0;
      r_wr_data  <= 32'd0;
      r_q_vld    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en <= w_mem_own || w_deq || w_alu_direct;
      if (w_mem_own) begin
        r_wr_rd   <= mem_rd;
        r_wr_data <= mem_data;
      end else if (w_deq) begin
        r_wr_rd   <= r_q_rd[r_head];
        r_wr_data <= r_q_data[r_head];
      end else if (w_alu_direct) begin
        r_wr_rd   <= alu_rd;
        r_wr_data <= alu_data;
      end
      // Clear before set: when full, tail equals head and the new entry must win
      if (w_deq) begin
        r_q_vld[r_head] <= 1'b0;
        r_head          <= f_next(r_head);
      end
      if (w_enq) begin
        r_q_vld[r_tail] <= 1'b1;
        r_tail          <= f_next(r_tail);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rd[r_tail]   <= alu_rd;
      r_q_data[r_tail] <= alu_data;
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_rd    = r_wr_rd;
  assign wr_data  = r_wr_data;
  assign q_count  = r_count;
  assign overflow = r_overflow;
  assign stall    = (r_count >= c_depth_m1);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_pred_ok, mem_valid, mem_pred_ok;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        wr_en, stall, overflow;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;

  wb_port_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_pred_ok(alu_pred_ok),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_pred_ok(mem_pred_ok),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .stall(stall), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_pred_ok = 1;
    mem_valid = 0; mem_rd = 0; mem_data = 0; mem_pred_ok = 1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input logic ok);
    alu_valid = 1; alu_rd = rd; alu_data = d; alu_pred_ok = ok;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    mem_valid = 1; mem_rd = rd; mem_data = d; mem_pred_ok = 1;
  endtask

  // Checks the write port, occupancy and stall against hand-computed values
  task automatic expect_port(input string name, input logic en, input logic [4:0] rd,
                             input logic [31:0] d, input logic [2:0] cnt, input logic st);
    tests++;
    if (wr_en !== en || wr_rd !== rd || wr_data !== d || q_count !== cnt || stall !== st) begin
      fails++;
      $display("FAIL %s: got en=%0b rd=%0d data=%h cnt=%0d stall=%0b, want en=%0b rd=%0d data=%h cnt=%0d stall=%0b",
               name, wr_en, wr_rd, wr_data, q_count, stall, en, rd, d, cnt, st);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    expect_port("reset_state", 0, 0, 0, 0, 0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_overflow: got %0b want 0", overflow);
    end
    reset = 0;
  endtask

  task automatic test_alu_only();
    alu(5, 32'h11, 1);
    tick();
    expect_port("alu_only_c1", 1, 5, 32'h11, 0, 0);
    idle();
    tick();
    expect_port("alu_only_hold", 0, 5, 32'h11, 0, 0);
  endtask

  task automatic test_collision();
    mem(3, 32'hAA); alu(4, 32'hBB, 1);
    tick();
    expect_port("collision_c1", 1, 3, 32'hAA, 1, 1);
    idle();
    tick();
    expect_port("collision_c2", 1, 4, 32'hBB, 0, 0);
    tick();
    expect_port("collision_c3", 0, 4, 32'hBB, 0, 0);
  endtask

  task automatic test_same_rd();
    mem(7, 32'h1); alu(7, 32'h2, 1);
    tick();
    expect_port("same_rd_c1", 1, 7, 32'h2, 0, 0);
    idle();
    tick();
    expect_port("same_rd_c2", 0, 7, 32'h2, 0, 0);
  endtask

  task automatic test_filter();
    alu(0, 32'h55, 1);
    tick();
    expect_port("filter_rd0", 0, 7, 32'h2, 0, 0);
    alu(30, 32'h66, 1);
    tick();
    expect_port("filter_rd30", 0, 7, 32'h2, 0, 0);
    alu(9, 32'h77, 0);
    mem(8, 32'h88); mem_pred_ok = 0;
    tick();
    expect_port("filter_pred", 0, 7, 32'h2, 0, 0);
    // Filtered MEM must not block a valid ALU request from writing directly
    mem(30, 32'h99); alu(12, 32'h12, 1);
    tick();
    expect_port("filter_mem30", 1, 12, 32'h12, 0, 0);
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    mem(10, 32'h10); alu(20, 32'hA0, 1);
    tick();
    expect_port("b2b_c1", 1, 10, 32'h10, 1, 1);
    mem(11, 32'h1B); alu(21, 32'hA1, 1);
    tick();
    expect_port("b2b_c2", 1, 11, 32'h1B, 2, 1);
    idle(); alu(22, 32'hA2, 1);
    tick();
    expect_port("b2b_full_drain", 1, 20, 32'hA0, 2, 1);
    idle(); mem(21, 32'hFF);
    tick();
    expect_port("b2b_mem_suppr", 1, 21, 32'hA1, 1, 1);
    idle();
    tick();
    expect_port("b2b_last", 1, 22, 32'hA2, 0, 0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_overflow: got %0b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    mem(13, 32'hC0); alu(23, 32'hD0, 1);
    tick();
    expect_port("ovf_c1", 1, 13, 32'hC0, 1, 1);
    mem(14, 32'hC1); alu(24, 32'hD1, 1);
    tick();
    expect_port("ovf_c2", 1, 14, 32'hC1, 2, 1);
    mem(15, 32'hC2); alu(25, 32'hD2, 1);
    tick();
    expect_port("ovf_c3", 1, 15, 32'hC2, 2, 1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %0b want 1", overflow);
    end
    mem(16, 32'hC3); idle(); mem(16, 32'hC3);
    tick();
    expect_port("ovf_hold_q", 1, 16, 32'hC3, 2, 1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: got %0b want 1", overflow);
    end
  endtask

  task automatic test_reset_midop();
    idle();
    reset = 1;
    tick();
    expect_port("midrst_state", 0, 0, 0, 0, 0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL midrst_overflow: got %0b want 0", overflow);
    end
    reset = 0;
    alu(9, 32'h99, 1);
    tick();
    expect_port("post_rst_accept", 1, 9, 32'h99, 0, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_port("post_rst_no_stale", 0, 9, 32'h99, 0, 0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_same_rd();
    test_filter();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, ALU deferral queue depth; legal values 2 or 4.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 alu_valid  in  1  ALU writeback request this cycle.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 alu_pred_ok  in  1  ALU predicate passed (1 = commit).
REQ-008 mem_valid  in  1  load writeback request this cycle.
REQ-009 mem_rd  in  5  load destination register.
REQ-010 mem_data  in  32  load data.
REQ-011 mem_pred_ok  in  1  load predicate passed.
REQ-012 wr_en  out  1  register-file write enable, registered.
REQ-013 wr_rd  out  5  register-file write address, registered.
REQ-014 wr_data  out  32  register-file write data, registered.
REQ-015 stall  out  1  backpressure to the fetch and decode stages.
REQ-016 q_count  out  3  current queue occupancy, 0..DEPTH.
REQ-017 overflow  out  1  sticky error flag: an ALU request was lost.

Function
REQ-018 Filter: a request with pred_ok=0, rd=0, or rd=30 SHALL be discarded. It is never queued or written, and it consumes no port slot.
REQ-019 Port owner: a valid filtered MEM request SHALL always own the single write port in its cycle.
REQ-020 Otherwise, if the queue is non-empty, the queue head SHALL own the port.
REQ-021 Otherwise, a valid filtered ALU request SHALL own the port directly, bypassing the queue.
REQ-022 An ALU request that does not own the port SHALL be enqueued at the tail in the same cycle.
REQ-023 Enqueue and dequeue in the same cycle SHALL be legal. q_count is unchanged in that case, and the head write precedes the new entry.
REQ-024 Age rule: a MEM request is older than every queued or simultaneous ALU request.
REQ-025 A MEM request SHALL be suppressed (no write, port left to the queue/ALU rule) when its mem_rd equals the rd of any valid queue entry or of a simultaneous filtered ALU request.
REQ-026 Writes SHALL be issued in ALU program order. The queue is FIFO, and a direct ALU write never overtakes a queued entry.
REQ-027 Latency: the port owner in cycle N SHALL appear on wr_en/wr_rd/wr_data in cycle N+1 for exactly one cycle.
REQ-028 When no owner exists, wr_en SHALL be 0 and wr_rd/wr_data SHALL hold their previous values.
REQ-029 stall SHALL be combinational from registered state: 1 when q_count >= DEPTH-1, else 0.
REQ-030 Full case: when q_count == DEPTH, the ALU request cannot be enqueued, and a MEM owner blocks the dequeue. The ALU request SHALL be dropped and overflow SHALL set and remain 1 until reset.
REQ-031 Full case with no MEM owner: the head drains and the ALU request enqueues, so no drop occurs.
REQ-032 Queue pointers SHALL wrap modulo DEPTH.
REQ-033 q_count SHALL never exceed DEPTH or go below 0.

Reset
REQ-034 While reset=1: wr_en=0, wr_rd=0, wr_data=0, q_count=0, overflow=0, stall=0, all queue entries invalid, pointers 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries without issuing any write.
REQ-036 The first cycle after reset deassertion SHALL accept requests normally.

Verification
REQ-037 ALU only: alu_valid, rd=5, data=0x11, pred_ok=1 in cycle 0 -> cycle 1 shows wr_en=1, wr_rd=5, wr_data=0x11; q_count stays 0.
REQ-038 Collision: in cycle 0, MEM rd=3/0xAA and ALU rd=4/0xBB. Result: cycle 1 writes r3=0xAA, cycle 2 writes r4=0xBB. q_count is 1 in cycle 1 and 0 in cycle 2. stall=1 in cycle 1 (DEPTH=2).
REQ-039 Same-rd suppression: in cycle 0, MEM rd=7/0x1 and ALU rd=7/0x2. Result: only one write, r7=0x2 in cycle 1; the MEM write never appears.
REQ-040 Filtering: ALU rd=0, rd=30, and pred_ok=0 in successive cycles -> wr_en stays 0 and q_count stays 0 throughout.
REQ-041 Overflow: with DEPTH=2, drive MEM and ALU (distinct rd) valid for 3 consecutive cycles. Result: q_count reaches 2, the third ALU request is dropped, overflow=1 and it stays 1.
REQ-042 Reset mid-op: with q_count=2, assert reset for 1 cycle. Result: q_count=0, overflow=0, and no queued write is ever issued.
